// File: rtl/mult_result_checker.sv
// mult_result_checker: receive-side checker for the multiplier experiments.
// Samples operands on strt, builds the expected product with an N-step
// shift-add reference, captures the DUT's first result, compares the two and
// keeps saturating pass/fail/timeout/drop counters plus the DUT latency.
module mult_result_checker #(
    parameter int N       = 16,
    parameter int TIMEOUT = 30
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           strt,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [2*N-1:0] dut_p,
    input  logic           dut_done,
    output logic           busy,
    output logic [2*N-1:0] exp_p,
    output logic           mismatch,
    output logic [15:0]    pass_cnt,
    output logic [15:0]    fail_cnt,
    output logic [7:0]     timeout_cnt,
    output logic [7:0]     drop_cnt,
    output logic [7:0]     last_latency
);
    localparam int         SW  = $clog2(N + 1);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

    state_t         state;
    logic [2*N-1:0] opa_sh;    // multiplicand, shifted left one place per step
    logic [N-1:0]   opb_sh;    // multiplier, shifted right one place per step
    logic [2*N-1:0] acc;
    logic [2*N-1:0] dut_cap;
    logic [SW-1:0]  step;
    logic           ref_done;
    logic           dut_seen;
    logic [7:0]     lat;

    logic           ref_done_nxt;
    logic           seen_nxt;
    logic [2*N-1:0] acc_nxt;

    // Look-ahead flags so the CHECK/timeout decision sees this cycle's step and strobe
    always_comb begin
        ref_done_nxt = ref_done || (step == SW'(N - 1));
        seen_nxt     = dut_seen || dut_done;
        acc_nxt      = acc;
        if (!ref_done && opb_sh[0])
            acc_nxt = acc + opa_sh;
    end

    assign busy = (state != IDLE);

    // Transaction FSM, reference multiplier and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            opa_sh       <= '0;
            opb_sh       <= '0;
            acc          <= '0;
            dut_cap      <= '0;
            step         <= '0;
            ref_done     <= 1'b0;
            dut_seen     <= 1'b0;
            lat          <= '0;
            exp_p        <= '0;
            mismatch     <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            timeout_cnt  <= '0;
            drop_cnt     <= '0;
            last_latency <= '0;
        end else begin
            mismatch <= 1'b0;
            // Operands arriving while a transaction is open are counted and discarded
            if (strt && state != IDLE && drop_cnt != '1)
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (strt) begin
                        opa_sh   <= {{N{1'b0}}, a};
                        opb_sh   <= b;
                        acc      <= '0;
                        step     <= '0;
                        ref_done <= 1'b0;
                        lat      <= 8'd1;
                        dut_seen <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (lat != '1)
                        lat <= lat + 8'd1;
                    if (!ref_done) begin
                        acc      <= acc_nxt;
                        opa_sh   <= opa_sh << 1;
                        opb_sh   <= opb_sh >> 1;
                        step     <= step + SW'(1);
                        ref_done <= ref_done_nxt;
                    end
                    // Only the first result of a transaction counts
                    if (dut_done && !dut_seen) begin
                        dut_cap      <= dut_p;
                        last_latency <= lat;
                        dut_seen     <= 1'b1;
                    end
                    if (seen_nxt && ref_done_nxt) begin
                        state <= CHECK;
                    end else if (lat == TMO && !seen_nxt) begin
                        if (timeout_cnt != '1)
                            timeout_cnt <= timeout_cnt + 8'd1;
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    exp_p <= acc;
                    if (acc == dut_cap) begin
                        if (pass_cnt != '1)
                            pass_cnt <= pass_cnt + 16'd1;
                    end else begin
                        if (fail_cnt != '1)
                            fail_cnt <= fail_cnt + 16'd1;
                        mismatch <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
